// File: rtl/dst7_pkg.sv
// rtl/dst7_pkg.sv - constants, coefficient tables and rounding helper for the 4-point DST-VII core
package dst7_pkg;

    localparam int C29 = 29;
    localparam int C55 = 55;
    localparam int C74 = 74;
    localparam int C84 = 84;

    // Which constant magnitude a matrix entry uses
    typedef enum logic [1:0] {
        SEL_29 = 2'd0,
        SEL_55 = 2'd1,
        SEL_74 = 2'd2,
        SEL_84 = 2'd3
    } sel_t;

    // Sign applied to the selected product
    typedef enum logic [1:0] {
        SGN_ZERO = 2'd0,
        SGN_POS  = 2'd1,
        SGN_NEG  = 2'd2
    } sgn_t;

    // Indexed [row k][column n]
    localparam sel_t SEL_TAB [4][4] = '{
        '{SEL_29, SEL_55, SEL_74, SEL_84},
        '{SEL_74, SEL_74, SEL_74, SEL_74},
        '{SEL_84, SEL_29, SEL_74, SEL_55},
        '{SEL_55, SEL_84, SEL_74, SEL_29}
    };

    localparam sgn_t SGN_TAB [4][4] = '{
        '{SGN_POS, SGN_POS, SGN_POS,  SGN_POS},
        '{SGN_POS, SGN_POS, SGN_ZERO, SGN_NEG},
        '{SGN_POS, SGN_NEG, SGN_NEG,  SGN_POS},
        '{SGN_POS, SGN_NEG, SGN_POS,  SGN_NEG}
    };

    // Row magnitude sums peak at 242 < 2^8, so eight guard bits keep every sum exact
    function automatic int acc_w(input int in_w);
        return in_w + 8;
    endfunction

    // Round half up by arithmetic shift, then optionally clip to a signed out_w range
    function automatic logic signed [31:0] round_clip(
        input logic signed [31:0] sum,
        input int                 shift,
        input int                 out_w,
        input logic               sat
    );
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        r = sum;
        if (shift > 0) begin
            r = sum + (32'sd1 <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (sat && (r > hi)) begin
            r = hi;
        end else if (sat && (r < lo)) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/dst7_mcm4.sv
// rtl/dst7_mcm4.sv - multiplierless x*{29,55,74,84} using shared x*7 and x*21 terms
module dst7_mcm4 import dst7_pkg::*; #(
    parameter int IN_W = 9
) (
    input  logic signed [IN_W-1:0]          x,
    output logic signed [acc_w(IN_W)-1:0]   p29,
    output logic signed [acc_w(IN_W)-1:0]   p55,
    output logic signed [acc_w(IN_W)-1:0]   p74,
    output logic signed [acc_w(IN_W)-1:0]   p84
);

    localparam int P_W = acc_w(IN_W);

    logic signed [P_W-1:0] xe;
    logic signed [P_W-1:0] x7;
    logic signed [P_W-1:0] x21;

    // Shared terms: 7 = 8-1, 21 = 2*7+7; outputs: 29 = 21+8, 55 = 56-1, 74 = 42+32, 84 = 4*21
    always_comb begin
        xe  = {{(P_W-IN_W){x[IN_W-1]}}, x};
        x7  = (xe <<< 3) - xe;
        x21 = (x7 <<< 1) + x7;
        p29 = x21 + (xe <<< 3);
        p55 = (x7 <<< 3) - xe;
        p74 = (x21 <<< 1) + (xe <<< 5);
        p84 = x21 <<< 2;
    end

endmodule

// File: rtl/dst7_4pt_serial.sv
// rtl/dst7_4pt_serial.sv - serial 4-point DST-VII forward transform core (DST7_SAT_EN selects clipping over wrap)
module dst7_4pt_serial import dst7_pkg::*; #(
    parameter int IN_W  = 9,
    parameter int SHIFT = 1,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y0,
    output logic signed [OUT_W-1:0] y1,
    output logic signed [OUT_W-1:0] y2,
    output logic signed [OUT_W-1:0] y3
);

    localparam int ACC_W = acc_w(IN_W);

`ifdef DST7_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic [1:0]              cnt;
    logic                    accept;
    logic                    last;
    logic signed [ACC_W-1:0] p29;
    logic signed [ACC_W-1:0] p55;
    logic signed [ACC_W-1:0] p74;
    logic signed [ACC_W-1:0] p84;
    logic signed [ACC_W-1:0] mag  [4];
    logic signed [ACC_W-1:0] term [4];
    logic signed [ACC_W-1:0] fsum [4];
    logic signed [ACC_W-1:0] acc  [4];
    logic signed [OUT_W-1:0] ynext [4];
    logic signed [OUT_W-1:0] yreg  [4];

    dst7_mcm4 #(.IN_W(IN_W)) u_mcm (
        .x   (in_data),
        .p29 (p29),
        .p55 (p55),
        .p74 (p74),
        .p84 (p84)
    );

    // Only the completing sample stalls, and only while the previous vector is still held
    assign in_ready = !((cnt == 2'd3) && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = accept && (cnt == 2'd3);

    // Per row: pick the product for column cnt, apply its sign, form the running and rounded sums
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mag[k]   = '0;
            term[k]  = '0;
            case (SEL_TAB[k][cnt])
                SEL_29:  mag[k] = p29;
                SEL_55:  mag[k] = p55;
                SEL_74:  mag[k] = p74;
                default: mag[k] = p84;
            endcase
            case (SGN_TAB[k][cnt])
                SGN_POS: term[k] = mag[k];
                SGN_NEG: term[k] = -mag[k];
                default: term[k] = '0;
            endcase
            fsum[k]  = acc[k] + term[k];
            ynext[k] = OUT_W'(round_clip(32'(fsum[k]), SHIFT, OUT_W, SAT));
        end
    end

    // Sample counter and column accumulation; column 0 restarts the sums
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                acc[k] <= '0;
            end
        end else if (accept) begin
            cnt <= cnt + 2'd1;
            for (int k = 0; k < 4; k++) begin
                acc[k] <= (cnt == 2'd0) ? term[k] : fsum[k];
            end
        end
    end

    // Single-entry output register; a new load wins over a same-cycle consume
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                yreg[k] <= '0;
            end
        end else if (last) begin
            out_valid <= 1'b1;
            for (int k = 0; k < 4; k++) begin
                yreg[k] <= ynext[k];
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign y0 = yreg[0];
    assign y1 = yreg[1];
    assign y2 = yreg[2];
    assign y3 = yreg[3];

endmodule

// File: tb/tb_dst7_4pt_serial.sv
// tb/tb_dst7_4pt_serial.sv - directed and randomized checks of the serial DST-VII core
module tb_dst7_4pt_serial;
    import dst7_pkg::*;

    localparam int IN_W  = 9;
    localparam int SHIFT = 1;
    localparam int OUT_W = 16;
    localparam int SAT_OUT_W = 12;
    localparam int NVEC  = 1000;

    localparam int M [4][4] = '{
        '{C29,  C55,  C74,  C84},
        '{C74,  C74,  0,   -C74},
        '{C84, -C29, -C74,  C55},
        '{C55, -C84,  C74, -C29}
    };

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] y0, y1, y2, y3;
    logic signed [OUT_W-1:0] ya [4];

    logic                        s_valid;
    logic                        s_ready;
    logic signed [IN_W-1:0]      s_data;
    logic                        s_out_valid;
    logic                        s_out_ready;
    logic signed [SAT_OUT_W-1:0] s_y0, s_y1, s_y2, s_y3;

    int n_pass;
    int n_total;

    dst7_4pt_serial #(.IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3)
    );

    dst7_4pt_serial #(.IN_W(IN_W), .SHIFT(1), .OUT_W(SAT_OUT_W)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_valid),
        .in_ready  (s_ready),
        .in_data   (s_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .y0        (s_y0),
        .y1        (s_y1),
        .y2        (s_y2),
        .y3        (s_y3)
    );

    assign ya[0] = y0;
    assign ya[1] = y1;
    assign ya[2] = y2;
    assign ya[3] = y3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int fit(input int r, input int w);
        int m;
`ifdef DST7_SAT_EN
        m = r;
        if (m > (1 << (w - 1)) - 1) m = (1 << (w - 1)) - 1;
        if (m < -(1 << (w - 1)))    m = -(1 << (w - 1));
`else
        m = r & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m = m - (1 << w);
`endif
        return m;
    endfunction

    function automatic int ref_y(input int k, input int x0, input int x1, input int x2, input int x3);
        int s;
        s = M[k][0] * x0 + M[k][1] * x1 + M[k][2] * x2 + M[k][3] * x3;
        s = (s + ((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0)) >>> SHIFT;
        return fit(s, OUT_W);
    endfunction

    // Present one sample and hold it until the core takes it (bounded)
    task automatic push(input int v);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = v[IN_W-1:0];
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) chk("push_timeout", guard, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_vec(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_y0"}, y0, e0);
        chk({tag, "_y1"}, y1, e1);
        chk({tag, "_y2"}, y2, e2);
        chk({tag, "_y3"}, y3, e3);
    endtask

    initial begin
        int xs [4];
        int exp_q [$];
        int idx, nsent, ncons, cyc, cur, e, s_exp;
        bit took;

        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk_vec("rst", 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Unit impulse and latency
        push(2); push(0); push(0);
        chk("lat_pre", out_valid, 0);
        push(0);
        chk("lat_ov", out_valid, 1);
        chk_vec("imp", 29, 74, 84, 55);
        @(negedge clk);
        chk("imp_consumed", out_valid, 0);

        // DC inputs
        push(1); push(1); push(1); push(1);
        chk_vec("dc1", 121, 37, 18, 8);
        push(-256); push(-256); push(-256); push(-256);
        chk("dcneg_y0", y0, -30976);
        @(negedge clk);

        // Backpressure: A held while B streams
        out_ready = 1'b0;
        push(1); push(1); push(1); push(1);
        chk("bp_a_ov", out_valid, 1);
        chk("bp_a_y0", y0, 121);
        push(2);
        chk("bp_b1_ready", in_ready, 1);
        push(0);
        chk("bp_b2_ready", in_ready, 1);
        push(0);
        #1;
        chk("bp_b3_stall", in_ready, 0);
        in_valid = 1'b1;
        in_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_y0", y0, 121);
        chk("bp_hold_y1", y1, 37);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_ov_stays", out_valid, 1);
        chk_vec("bp_b", 29, 74, 84, 55);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Reset mid-vector with an output pending
        out_ready = 1'b0;
        push(3); push(3); push(3); push(3);
        push(5); push(7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        chk_vec("mrst", 0, 0, 0, 0);
        out_ready = 1'b1;
        push(2); push(0); push(0); push(0);
        chk_vec("mrst_imp", 29, 74, 84, 55);
        @(negedge clk);

        // Random traffic against the matrix model
        idx = 0; nsent = 0; ncons = 0; cyc = 0; cur = 0;
        while (ncons < NVEC && cyc < 40000) begin
            if (!in_valid && nsent < 4 * NVEC && $urandom_range(0, 3) != 0) begin
                cur = int'($urandom_range(0, 511)) - 256;
                in_valid = 1'b1;
                in_data = cur[IN_W-1:0];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            took = in_valid && in_ready;
            if (out_valid && out_ready) begin
                for (int k = 0; k < 4; k++) begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    else e = 999999;
                    chk("rand_y", ya[k], e);
                end
                ncons++;
            end
            if (took) begin
                xs[idx] = cur;
                idx++;
                nsent++;
                if (idx == 4) begin
                    idx = 0;
                    for (int k = 0; k < 4; k++) exp_q.push_back(ref_y(k, xs[0], xs[1], xs[2], xs[3]));
                end
            end
            @(negedge clk);
            cyc++;
            if (took) in_valid = 1'b0;
        end
        chk("rand_done", ncons, NVEC);
        out_ready = 1'b1;

        // Narrow output: clip or wrap of 30855
        s_valid = 1'b1;
        s_data = 9'sd255;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
`ifdef DST7_SAT_EN
        s_exp = 2047;
`else
        s_exp = -1913;
`endif
        chk("sat_ov", s_out_valid, 1);
        chk("sat_y0", s_y0, s_exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dst7_4pt_serial.md
# dst7_4pt_serial

Sequential, parametrised 4-point DST-VII 1-D forward transform core for the VVC transform datapath. It accepts one residual sample per cycle over a valid/ready handshake and accumulates the column products in four accumulators. The products are built from multiplierless shift-add constants 29/55/74/84. After the fourth sample it emits one rounded, width-controlled coefficient vector y0..y3 through a single-entry output register with backpressure.

## Interface
- IN_W, 9: signed input sample width (2..16).
- SHIFT, 1: right shift applied with rounding to each accumulator (0..8).
- OUT_W, 16: signed output coefficient width (IN_W+8-SHIFT gives lossless range).
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data carries a sample.
- in_ready  output  1  core accepts a sample this cycle.
- in_data  input  IN_W  signed sample x[n], n = 0..3 in arrival order.
- out_valid  output  1  y0..y3 hold a completed vector.
- out_ready  input  1  downstream accepts the vector.
- y0, y1, y2, y3  output  OUT_W each  signed coefficients.

## Operation
- Matrix rows: y0 = 29,55,74,84; y1 = 74,74,0,-74; y2 = 84,-29,-74,55; y3 = 55,-84,74,-29. Each row is applied to x0..x3.
- Products x·{29,55,74,84} are formed by shift-add only, with no `*` operator. Column n selects and negates per the matrix.
- Sample index counter cnt (2 bits, 0..3) advances on every accepted sample (in_valid && in_ready) and wraps 3→0.
- Accumulators acc0..acc3 are ACC_W = IN_W+8 bits signed, which is exact because the max row |coef| sum is 242 < 256.
  - On accept with cnt==0: acc_k loads the product.
  - On accept with cnt==1..2: acc_k adds the product.
  - On accept with cnt==3: the final sum (acc_k + product) is rounded and written straight to the output register.
- Rounding: r = (sum + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, using an arithmetic shift.
- Width to OUT_W: see Configuration.
- Output register: loaded on the cnt==3 accept, which sets out_valid. out_valid clears on out_ready unless a new load occurs in the same cycle.
- in_ready = !(cnt==3 && out_valid && !out_ready). The pipeline stalls only the completing sample while the previous vector is unconsumed.
- Simultaneous out_ready and completing accept: the new vector loads and out_valid stays 1.
- Reset values: cnt=0, acc0..3=0, out_valid=0, y0..y3=0. in_ready is 1 after reset.
- rst mid-vector discards the partial accumulation and any pending output. The next accepted sample is x0.
- y0..y3 hold stable while out_valid && !out_ready.

## Timing
- Throughput: one sample per cycle, one vector per 4 cycles sustained with out_ready tied high.
- Latency: out_valid rises the cycle after the 4th sample is accepted.
- in_ready is combinational from out_ready, cnt and out_valid. There is no combinational path from in_valid to in_ready.
- Outputs are registered, with no combinational path from in_data to y*.

## Configuration
- DST7_SAT_EN defined: r is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- DST7_SAT_EN undefined: r is truncated to its low OUT_W bits (two's-complement wrap).
- The macro has no effect on timing or handshake.

## Structure
- Package dst7_pkg holds:
  - constants C29, C55, C74, C84;
  - the 4×4 coefficient-sign table;
  - function acc_w(IN_W) = IN_W+8;
  - the rounding/saturation helper function.
- Sub-module dst7_mcm4 is combinational. It takes a signed IN_W input and outputs signed IN_W+8 products p29, p55, p74, p84 using shared shift-add terms (x·7, x·21). The core instantiates it once.

## Test plan
- Unit impulse, SHIFT=1, x=[2,0,0,0] with out_ready=1 → y=[29,74,84,55], and out_valid rises 1 cycle after the 4th accept.
- DC input, SHIFT=1, x=[1,1,1,1] → y=[121,37,18,8]. Also x=[-256,-256,-256,-256] → y0=-30976.
- Saturation with OUT_W=12, SHIFT=1, x=[255,255,255,255]:
  - with DST7_SAT_EN → y0=2047;
  - without DST7_SAT_EN → y0=-1913 (0x887).
- Backpressure:
  - Hold out_ready=0 after vector A; stream vector B. in_ready drops only at B's 4th sample and y stays at A.
  - Raise out_ready; B's 4th sample is accepted that same cycle, out_valid stays 1 and y updates to B.
- Reset after 2 samples of a vector → cnt=0, out_valid=0, y*=0. The next 4 samples [2,0,0,0] produce [29,74,84,55], with no residue from the prior samples.
- Back-to-back random vectors with random valid/ready gaps (≥1000 vectors) → match a reference-model matrix product with identical rounding and clipping.
